// File: rtl/override_pkg.sv
`default_nettype none
// ============================================================================
// Module   : override_pkg
// Purpose  : Shared types for the value-override controller: the per-channel
//            override state and its 2-bit encoding.
// Revision : 1.0 - initial release
// ============================================================================
package override_pkg;

  localparam int ST_W = 2;

  // Bit 1 = forced, bit 0 = assigned; the encoding is visible on ch_state.
  typedef enum logic [ST_W-1:0] {
    NORM     = 2'd0,
    ASGN     = 2'd1,
    FRC      = 2'd2,
    FRC_ASGN = 2'd3
  } ovr_state_e;

  function automatic logic is_forced(ovr_state_e s);
    return (s == FRC) || (s == FRC_ASGN);
  endfunction

  function automatic logic is_assigned(ovr_state_e s);
    return (s == ASGN) || (s == FRC_ASGN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/override_chan.sv
`default_nettype none
// ============================================================================
// Module   : override_chan
// Purpose  : One override channel: base/assign/force registers, the
//            force > assign > procedural state machine and registered output.
// Revision : 1.0 - initial release
// ============================================================================
module override_chan
  import override_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RELEASE_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fn_we,
  input  logic [WIDTH-1:0] fn_wdata,
  input  logic             dep_we,
  input  logic [WIDTH-1:0] dep_data,
  input  logic             asg_set,
  input  logic             asg_clr,
  input  logic [WIDTH-1:0] asg_data,
  input  logic             frc_set,
  input  logic             frc_rel,
  input  logic [WIDTH-1:0] frc_data,
  output logic [WIDTH-1:0] dout,
  output logic [ST_W-1:0]  state,
  output logic             cmd_err
);

  ovr_state_e       state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] asg_q, asg_d;
  logic [WIDTH-1:0] frc_q, frc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             asg_on, frc_on, clr_ok, rel_ok, asg_nx, frc_nx;

  // Next state, register updates and effective value; every command is judged
  // against the current state, so assign and force bits evolve independently.
  always_comb begin
    asg_on  = is_assigned(state_q);
    frc_on  = is_forced(state_q);
    clr_ok  = asg_clr && asg_on;
    rel_ok  = frc_rel && frc_on;
    cmd_err = (asg_clr && !asg_on) || (frc_rel && !frc_on);

    asg_nx = asg_on;
    if (asg_set)     asg_nx = 1'b1;
    else if (clr_ok) asg_nx = 1'b0;

    frc_nx = frc_on;
    if (frc_set)     frc_nx = 1'b1;
    else if (rel_ok) frc_nx = 1'b0;

    unique case ({frc_nx, asg_nx})
      2'b00:   state_d = NORM;
      2'b01:   state_d = ASGN;
      2'b10:   state_d = FRC;
      default: state_d = FRC_ASGN;
    endcase

    asg_d = asg_set ? asg_data : asg_q;
    frc_d = frc_set ? frc_data : frc_q;

    // Base priority: release copy > deassign copy > deposit > functional write.
    base_d = base_q;
    if (rel_ok && (RELEASE_HOLD != 0))  base_d = frc_q;
    else if (clr_ok)                    base_d = asg_q;
    else if (dep_we)                    base_d = dep_data;
    else if (fn_we && state_q == NORM)  base_d = fn_wdata;

    if (frc_nx)      dout_d = frc_d;
    else if (asg_nx) dout_d = asg_d;
    else             dout_d = base_d;
  end

  // Channel register bank with synchronous reset clearing all overrides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORM;
      base_q  <= '0;
      asg_q   <= '0;
      frc_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      asg_q   <= asg_d;
      frc_q   <= frc_d;
      dout_q  <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/override_ctrl_bank.sv
`default_nettype none
// ============================================================================
// Module   : override_ctrl_bank
// Purpose  : NCH-channel value-override controller. Decodes the deposit,
//            assign and force command ports onto channels, flags illegal
//            commands and instantiates one override_chan per channel.
// Revision : 1.0 - initial release
// ============================================================================
module override_ctrl_bank
  import override_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NCH          = 4,
  parameter int RELEASE_HOLD = 1,
  parameter int CW           = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       fn_we,
  input  logic [NCH*WIDTH-1:0] fn_wdata,
  input  logic                 dep_we,
  input  logic [CW-1:0]        dep_ch,
  input  logic [WIDTH-1:0]     dep_data,
  input  logic                 asg_set,
  input  logic                 asg_clr,
  input  logic [CW-1:0]        asg_ch,
  input  logic [WIDTH-1:0]     asg_data,
  input  logic                 frc_set,
  input  logic                 frc_rel,
  input  logic [CW-1:0]        frc_ch,
  input  logic [WIDTH-1:0]     frc_data,
  output logic [NCH*WIDTH-1:0] dout,
  output logic [NCH*2-1:0]     ch_state,
  output logic                 err
);

  logic [NCH-1:0] w_dep_v, w_asg_set_v, w_asg_clr_v, w_frc_set_v, w_frc_rel_v;
  logic [NCH-1:0] w_chan_err;
  logic           w_asg_pair, w_frc_pair, w_dep_ok, w_asg_ok, w_frc_ok;
  logic           err_q, err_d;

  // Channel decode; conflicting pairs and out-of-range channels select nothing.
  always_comb begin
    w_asg_pair = asg_set && asg_clr;
    w_frc_pair = frc_set && frc_rel;
    w_dep_ok   = int'(dep_ch) < NCH;
    w_asg_ok   = int'(asg_ch) < NCH;
    w_frc_ok   = int'(frc_ch) < NCH;
    for (int i = 0; i < NCH; i++) begin
      w_dep_v[i]     = dep_we && (int'(dep_ch) == i);
      w_asg_set_v[i] = asg_set && !w_asg_pair && (int'(asg_ch) == i);
      w_asg_clr_v[i] = asg_clr && !w_asg_pair && (int'(asg_ch) == i);
      w_frc_set_v[i] = frc_set && !w_frc_pair && (int'(frc_ch) == i);
      w_frc_rel_v[i] = frc_rel && !w_frc_pair && (int'(frc_ch) == i);
    end
    err_d = w_asg_pair || w_frc_pair
         || (dep_we && !w_dep_ok)
         || ((asg_set || asg_clr) && !w_asg_ok)
         || ((frc_set || frc_rel) && !w_frc_ok)
         || (|w_chan_err);
  end

  // Error pulse register, one cycle after the offending command.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    override_chan #(
      .WIDTH        (WIDTH),
      .RELEASE_HOLD (RELEASE_HOLD)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .fn_we    (fn_we[g]),
      .fn_wdata (fn_wdata[g*WIDTH +: WIDTH]),
      .dep_we   (w_dep_v[g]),
      .dep_data (dep_data),
      .asg_set  (w_asg_set_v[g]),
      .asg_clr  (w_asg_clr_v[g]),
      .asg_data (asg_data),
      .frc_set  (w_frc_set_v[g]),
      .frc_rel  (w_frc_rel_v[g]),
      .frc_data (frc_data),
      .dout     (dout[g*WIDTH +: WIDTH]),
      .state    (ch_state[g*2 +: 2]),
      .cmd_err  (w_chan_err[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_override_ctrl_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_override_ctrl_bank
// Purpose  : Self-checking bench for override_ctrl_bank. Three instances share
//            one command stream: NCH=4/hold, NCH=4/no-hold, NCH=3/hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_override_ctrl_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fn_we;
  logic [31:0] fn_wdata;
  logic        dep_we, asg_set, asg_clr, frc_set, frc_rel;
  logic [1:0]  dep_ch, asg_ch, frc_ch;
  logic [7:0]  dep_data, asg_data, frc_data;

  logic [31:0] dout_a, dout_b;
  logic [23:0] dout_c;
  logic [7:0]  ch_state_a, ch_state_b;
  logic [5:0]  ch_state_c;
  logic        err_a, err_b, err_c;

  logic [31:0] act_dout[3];
  logic [7:0]  act_state[3];
  logic        act_err[3];

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel a forced flag, an assigned flag and values.
  int         c_nch[3]  = '{4, 4, 3};
  int         c_hold[3] = '{1, 0, 1};
  bit         m_a[3][4], m_f[3][4];
  logic [7:0] m_base[3][4], m_av[3][4], m_fv[3][4];
  bit         m_err[3];

  always #5 clk = ~clk;

  override_ctrl_bank #(.WIDTH(8), .NCH(4), .RELEASE_HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .fn_we(fn_we), .fn_wdata(fn_wdata),
    .dep_we(dep_we), .dep_ch(dep_ch), .dep_data(dep_data),
    .asg_set(asg_set), .asg_clr(asg_clr), .asg_ch(asg_ch), .asg_data(asg_data),
    .frc_set(frc_set), .frc_rel(frc_rel), .frc_ch(frc_ch), .frc_data(frc_data),
    .dout(dout_a), .ch_state(ch_state_a), .err(err_a));

  override_ctrl_bank #(.WIDTH(8), .NCH(4), .RELEASE_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .fn_we(fn_we), .fn_wdata(fn_wdata),
    .dep_we(dep_we), .dep_ch(dep_ch), .dep_data(dep_data),
    .asg_set(asg_set), .asg_clr(asg_clr), .asg_ch(asg_ch), .asg_data(asg_data),
    .frc_set(frc_set), .frc_rel(frc_rel), .frc_ch(frc_ch), .frc_data(frc_data),
    .dout(dout_b), .ch_state(ch_state_b), .err(err_b));

  override_ctrl_bank #(.WIDTH(8), .NCH(3), .RELEASE_HOLD(1)) dut_c (
    .clk(clk), .rst(rst), .fn_we(fn_we[2:0]), .fn_wdata(fn_wdata[23:0]),
    .dep_we(dep_we), .dep_ch(dep_ch), .dep_data(dep_data),
    .asg_set(asg_set), .asg_clr(asg_clr), .asg_ch(asg_ch), .asg_data(asg_data),
    .frc_set(frc_set), .frc_rel(frc_rel), .frc_ch(frc_ch), .frc_data(frc_data),
    .dout(dout_c), .ch_state(ch_state_c), .err(err_c));

  assign act_dout[0]  = dout_a;
  assign act_dout[1]  = dout_b;
  assign act_dout[2]  = {8'h00, dout_c};
  assign act_state[0] = ch_state_a;
  assign act_state[1] = ch_state_b;
  assign act_state[2] = {2'b00, ch_state_c};
  assign act_err[0]   = err_a;
  assign act_err[1]   = err_b;
  assign act_err[2]   = err_c;

  // Apply one clock edge of the command rules to every modelled instance.
  task automatic model_step();
    bit e, asg_v, frc_v, na, nf;
    logic [7:0] nb, nav, nfv;
    int n;
    for (int k = 0; k < 3; k++) begin
      n = c_nch[k];
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_a[k][i] = 0; m_f[k][i] = 0;
          m_base[k][i] = 8'h00; m_av[k][i] = 8'h00; m_fv[k][i] = 8'h00;
        end
        m_err[k] = 0;
      end else begin
        e = 0;
        if (asg_set && asg_clr) e = 1;
        if (frc_set && frc_rel) e = 1;
        if (dep_we && int'(dep_ch) >= n) e = 1;
        if ((asg_set || asg_clr) && int'(asg_ch) >= n) e = 1;
        if ((frc_set || frc_rel) && int'(frc_ch) >= n) e = 1;
        asg_v = !(asg_set && asg_clr);
        frc_v = !(frc_set && frc_rel);
        for (int i = 0; i < n; i++) begin
          nb = m_base[k][i]; nav = m_av[k][i]; nfv = m_fv[k][i];
          na = m_a[k][i];    nf = m_f[k][i];
          // Lowest-priority base source first; later sources overwrite.
          if (fn_we[i] && !m_a[k][i] && !m_f[k][i]) nb = fn_wdata[i*8 +: 8];
          if (dep_we && int'(dep_ch) == i) nb = dep_data;
          if (asg_v && asg_clr && int'(asg_ch) == i) begin
            if (m_a[k][i]) begin nb = m_av[k][i]; na = 0; end
            else e = 1;
          end
          if (frc_v && frc_rel && int'(frc_ch) == i) begin
            if (m_f[k][i]) begin nf = 0; if (c_hold[k] != 0) nb = m_fv[k][i]; end
            else e = 1;
          end
          if (asg_v && asg_set && int'(asg_ch) == i) begin na = 1; nav = asg_data; end
          if (frc_v && frc_set && int'(frc_ch) == i) begin nf = 1; nfv = frc_data; end
          m_base[k][i] = nb; m_av[k][i] = nav; m_fv[k][i] = nfv;
          m_a[k][i] = na;    m_f[k][i] = nf;
        end
        m_err[k] = e;
      end
    end
  endtask

  function automatic logic [31:0] exp_dout(int k);
    logic [31:0] r = '0;
    for (int i = 0; i < c_nch[k]; i++)
      r[i*8 +: 8] = m_f[k][i] ? m_fv[k][i] : (m_a[k][i] ? m_av[k][i] : m_base[k][i]);
    return r;
  endfunction

  function automatic logic [7:0] exp_state(int k);
    logic [7:0] r = '0;
    for (int i = 0; i < c_nch[k]; i++) r[i*2 +: 2] = {m_f[k][i], m_a[k][i]};
    return r;
  endfunction

  task automatic clear_cmds();
    rst = 0; fn_we = '0; fn_wdata = '0;
    dep_we = 0; dep_ch = '0; dep_data = '0;
    asg_set = 0; asg_clr = 0; asg_ch = '0; asg_data = '0;
    frc_set = 0; frc_rel = 0; frc_ch = '0; frc_data = '0;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    clear_cmds(); rst = 1; fn_we = 4'hF; fn_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 0; fn_we = '0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_dout[k] !== 32'h0 || act_state[k] !== 8'h0 || act_err[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d: dout=%h state=%h err=%b expected 0/0/0",
                 k, act_dout[k], act_state[k], act_err[k]);
      end
    end
  endtask

  task automatic test_functional();
    clear_cmds(); fn_we = 4'b0001; fn_wdata = 32'h0000_000A;
    tick(); clear_cmds();
    checks++;
    if (dout_a[7:0] !== 8'h0A || ch_state_a !== 8'h00) begin
      failures++;
      $display("FAIL fn_write: dout0=%h state=%h expected 0a/00", dout_a[7:0], ch_state_a);
    end
  endtask

  task automatic test_assign();
    clear_cmds(); asg_set = 1; asg_ch = 2'd1; asg_data = 8'hB5; tick();
    clear_cmds(); fn_we = 4'b0010; fn_wdata = 32'h0000_1100; tick();
    checks++;
    if (dout_a[15:8] !== 8'hB5 || ch_state_a[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL assign_hold: dout1=%h state=%0d expected b5/1", dout_a[15:8], ch_state_a[3:2]);
    end
    clear_cmds(); asg_clr = 1; asg_ch = 2'd1; tick();
    checks++;
    if (dout_a[15:8] !== 8'hB5 || ch_state_a[3:2] !== 2'd0 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL deassign: dout1=%h state=%0d err=%b expected b5/0/0",
               dout_a[15:8], ch_state_a[3:2], err_a);
    end
    clear_cmds(); fn_we = 4'b0010; fn_wdata = 32'h0000_2200; tick();
    checks++;
    if (dout_a[15:8] !== 8'h22) begin
      failures++;
      $display("FAIL fn_after_deassign: dout1=%h expected 22", dout_a[15:8]);
    end
  endtask

  task automatic test_force_release();
    clear_cmds(); fn_we = 4'b0100; fn_wdata = 32'h000F_0000; tick();
    clear_cmds(); frc_set = 1; frc_ch = 2'd2; frc_data = 8'h99; tick();
    checks++;
    if (dout_a[23:16] !== 8'h99 || ch_state_a[5:4] !== 2'd2) begin
      failures++;
      $display("FAIL force: dout2=%h state=%0d expected 99/2", dout_a[23:16], ch_state_a[5:4]);
    end
    clear_cmds(); frc_rel = 1; frc_ch = 2'd2; tick();
    checks++;
    if (dout_a[23:16] !== 8'h99 || ch_state_a[5:4] !== 2'd0) begin
      failures++;
      $display("FAIL release_hold: dout2=%h state=%0d expected 99/0", dout_a[23:16], ch_state_a[5:4]);
    end
    checks++;
    if (dout_b[23:16] !== 8'h0F || ch_state_b[5:4] !== 2'd0) begin
      failures++;
      $display("FAIL release_revert: dout2=%h state=%0d expected 0f/0", dout_b[23:16], ch_state_b[5:4]);
    end
  endtask

  task automatic test_force_over_assign();
    clear_cmds(); asg_set = 1; asg_ch = 2'd3; asg_data = 8'h0B; tick();
    clear_cmds(); frc_set = 1; frc_ch = 2'd3; frc_data = 8'h09; tick();
    checks++;
    if (dout_a[31:24] !== 8'h09 || ch_state_a[7:6] !== 2'd3) begin
      failures++;
      $display("FAIL force_assign: dout3=%h state=%0d expected 09/3", dout_a[31:24], ch_state_a[7:6]);
    end
    clear_cmds(); frc_rel = 1; frc_ch = 2'd3; tick();
    checks++;
    if (dout_a[31:24] !== 8'h0B || ch_state_a[7:6] !== 2'd1) begin
      failures++;
      $display("FAIL release_to_assign: dout3=%h state=%0d expected 0b/1", dout_a[31:24], ch_state_a[7:6]);
    end
    clear_cmds(); dep_we = 1; dep_ch = 2'd3; dep_data = 8'h55; tick();
    clear_cmds(); asg_clr = 1; asg_ch = 2'd3; tick();
    clear_cmds();
    checks++;
    if (dout_a[31:24] !== 8'h0B || ch_state_a[7:6] !== 2'd0) begin
      failures++;
      $display("FAIL deassign_copy: dout3=%h state=%0d expected 0b/0", dout_a[31:24], ch_state_a[7:6]);
    end
  endtask

  task automatic test_errors();
    logic [7:0] st_c;
    clear_cmds(); frc_rel = 1; frc_ch = 2'd0; tick();
    clear_cmds();
    checks++;
    if (err_a !== 1'b1 || ch_state_a[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL rel_on_norm: err=%b state=%0d expected 1/0", err_a, ch_state_a[1:0]);
    end
    tick();
    checks++;
    if (err_a !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle: err=%b expected 0", err_a);
    end
    asg_set = 1; asg_clr = 1; asg_ch = 2'd0; asg_data = 8'h44; tick();
    clear_cmds();
    checks++;
    if (err_a !== 1'b1 || ch_state_a[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL set_clr_pair: err=%b state=%0d expected 1/0", err_a, ch_state_a[1:0]);
    end
    st_c = {2'b00, ch_state_c};
    asg_set = 1; asg_ch = 2'd3; asg_data = 8'h77; tick();
    clear_cmds();
    checks++;
    if (err_c !== 1'b1 || {2'b00, ch_state_c} !== st_c || err_a !== 1'b0) begin
      failures++;
      $display("FAIL ch_range: err_c=%b state_c=%h err_a=%b expected 1/%h/0",
               err_c, ch_state_c, err_a, st_c);
    end
    tick();
    checks++;
    if (err_c !== 1'b0 || ch_state_a[7:6] !== 2'd1) begin
      failures++;
      $display("FAIL ch_range_after: err_c=%b state_a3=%0d expected 0/1", err_c, ch_state_a[7:6]);
    end
  endtask

  task automatic test_same_cycle();
    clear_cmds(); asg_set = 1; asg_ch = 2'd1; asg_data = 8'h3C; tick();
    clear_cmds(); asg_clr = 1; asg_ch = 2'd1; frc_rel = 1; frc_ch = 2'd1; tick();
    clear_cmds();
    checks++;
    if (err_a !== 1'b1 || ch_state_a[3:2] !== 2'd0 || dout_a[15:8] !== 8'h3C) begin
      failures++;
      $display("FAIL clr_rel_same: err=%b state=%0d dout1=%h expected 1/0/3c",
               err_a, ch_state_a[3:2], dout_a[15:8]);
    end
  endtask

  task automatic test_reset_mid();
    clear_cmds(); asg_set = 1; asg_ch = 2'd0; asg_data = 8'hA1;
    frc_set = 1; frc_ch = 2'd0; frc_data = 8'hF2; tick();
    checks++;
    if (ch_state_a[1:0] !== 2'd3 || dout_a[7:0] !== 8'hF2) begin
      failures++;
      $display("FAIL pre_reset: state0=%0d dout0=%h expected 3/f2", ch_state_a[1:0], dout_a[7:0]);
    end
    rst = 1; fn_we = 4'hF; fn_wdata = 32'h1234_5678; frc_rel = 1; dep_we = 1; tick();
    clear_cmds();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_dout[k] !== 32'h0 || act_state[k] !== 8'h0 || act_err[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid inst%0d: dout=%h state=%h err=%b expected 0/0/0",
                 k, act_dout[k], act_state[k], act_err[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      fn_we    = 4'($urandom);
      fn_wdata = $urandom;
      dep_we   = ($urandom_range(0, 3) == 0);
      dep_ch   = 2'($urandom);
      dep_data = 8'($urandom);
      asg_set  = ($urandom_range(0, 2) == 0);
      asg_clr  = ($urandom_range(0, 2) == 0);
      asg_ch   = 2'($urandom);
      asg_data = 8'($urandom);
      frc_set  = ($urandom_range(0, 3) == 0);
      frc_rel  = ($urandom_range(0, 3) == 0);
      frc_ch   = 2'($urandom);
      frc_data = 8'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_dout[k] !== exp_dout(k) || act_state[k] !== exp_state(k) || act_err[k] !== m_err[k]) begin
          failures++;
          $display("FAIL random c%0d inst%0d: dout=%h state=%h err=%b expected %h/%h/%b",
                   c, k, act_dout[k], act_state[k], act_err[k],
                   exp_dout(k), exp_state(k), m_err[k]);
        end
      end
    end
    clear_cmds();
  endtask

  initial begin
    clear_cmds();
    test_reset();
    test_functional();
    test_assign();
    test_force_release();
    test_force_over_assign();
    test_errors();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
